// File: rtl/fetch_sequencer.sv
// Fetch stage: owns the PC, decodes instruction length, predicts the next PC and
// fills the F/D register. Define FETCH_PREDICT_TAKEN_EN to predict jXX/call as taken.
module fetch_sequencer #(
    parameter int                PC_WID   = 32,
    parameter logic [PC_WID-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_WID-1:0] imem_pc,
    input  logic [3:0]        imem_icode,
    input  logic [3:0]        imem_ifun,
    input  logic [3:0]        imem_rA,
    input  logic [3:0]        imem_rB,
    input  logic [PC_WID-1:0] imem_valC,
    input  logic              d_ready,
    input  logic              redirect_valid,
    input  logic [PC_WID-1:0] redirect_pc,
    output logic              d_valid,
    output logic [3:0]        d_icode,
    output logic [3:0]        d_ifun,
    output logic [3:0]        d_rA,
    output logic [3:0]        d_rB,
    output logic [PC_WID-1:0] d_valC,
    output logic [PC_WID-1:0] d_valP,
    output logic [PC_WID-1:0] d_pc,
    output logic              halted,
    output logic              instr_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_RET = 2'd1,
        ST_HALT     = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [PC_WID-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [3:0]        icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
    logic [PC_WID-1:0] valc_q, valc_d, valp_q, valp_d, dpc_q, dpc_d;

    logic [2:0]        ilen;
    logic              illegal;
    logic [PC_WID-1:0] valp;
    logic [PC_WID-1:0] pred_pc;

    always_comb begin
        ilen    = 3'd1;
        illegal = 1'b0;
        case (imem_icode)
            4'h0, 4'h1, 4'h9:       ilen = 3'd1;
            4'h2, 4'h6, 4'hA, 4'hB: ilen = 3'd2;
            4'h7, 4'h8:             ilen = 3'd5;
            4'h3, 4'h4, 4'h5:       ilen = 3'd6;
            default:                illegal = 1'b1;
        endcase
    end

    // Addition wraps naturally at 2^PC_WID.
    assign valp = pc_q + PC_WID'(ilen);

`ifdef FETCH_PREDICT_TAKEN_EN
    assign pred_pc = (imem_icode == 4'h7 || imem_icode == 4'h8) ? imem_valC : valp;
`else
    assign pred_pc = valp;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        valc_d  = valc_q;
        valp_d  = valp_q;
        dpc_d   = dpc_q;

        if (redirect_valid) begin
            // Redirect wins over stalls: squash F/D, issue nothing this cycle.
            state_d = ST_RUN;
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else begin
            if (valid_q && d_ready) valid_d = 1'b0;
            if (state_q == ST_RUN) begin
                if (illegal) begin
                    state_d = ST_ERROR;
                end else if (!valid_q || d_ready) begin
                    valid_d = 1'b1;
                    icode_d = imem_icode;
                    ifun_d  = imem_ifun;
                    ra_d    = imem_rA;
                    rb_d    = imem_rB;
                    valc_d  = imem_valC;
                    valp_d  = valp;
                    dpc_d   = pc_q;
                    pc_d    = pred_pc;
                    if (imem_icode == 4'h9) state_d = ST_WAIT_RET;
                    if (imem_icode == 4'h0) begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            icode_q <= '0;
            ifun_q  <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            valc_q  <= '0;
            valp_q  <= '0;
            dpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            dpc_q   <= dpc_d;
        end
    end

    assign imem_pc   = pc_q;
    assign d_valid   = valid_q;
    assign d_icode   = icode_q;
    assign d_ifun    = ifun_q;
    assign d_rA      = ra_q;
    assign d_rB      = rb_q;
    assign d_valC    = valc_q;
    assign d_valP    = valp_q;
    assign d_pc      = dpc_q;
    assign halted    = (state_q == ST_HALT);
    assign instr_err = (state_q == ST_ERROR);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: small program in a combinational memory model,
// stalls, redirects, illegal/halt handling and async reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_pc;
    logic [3:0]  imem_icode, imem_ifun, imem_rA, imem_rB;
    logic [31:0] imem_valC;
    logic        d_ready, redirect_valid;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [31:0] d_valC, d_valP, d_pc;
    logic        halted, instr_err;

    logic        ovr_en;
    logic [3:0]  ovr_icode;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_pc(imem_pc),
        .imem_icode(imem_icode), .imem_ifun(imem_ifun), .imem_rA(imem_rA),
        .imem_rB(imem_rB), .imem_valC(imem_valC),
        .d_ready(d_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .d_valid(d_valid), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
        .d_valC(d_valC), .d_valP(d_valP), .d_pc(d_pc),
        .halted(halted), .instr_err(instr_err)
    );

    // Program image; unlisted addresses hold nop.
    always_comb begin
        imem_icode = 4'h1;
        imem_ifun  = 4'h0;
        imem_rA    = 4'hF;
        imem_rB    = 4'hF;
        imem_valC  = 32'h0;
        if (ovr_en) begin
            imem_icode = ovr_icode;
            imem_valC  = 32'h300;
        end else begin
            case (imem_pc)
                32'h0:        begin imem_icode = 4'h3; imem_rB = 4'h2; imem_valC = 32'h100; end
                32'h6:        imem_icode = 4'h1;
                32'h7:        begin imem_icode = 4'h6; imem_ifun = 4'h1; imem_rA = 4'h0; imem_rB = 4'h3; end
                32'h9:        begin imem_icode = 4'h8; imem_valC = 32'h40; end
                32'h40:       imem_icode = 4'h9;
                32'h20:       imem_icode = 4'hD;
                32'hFFFFFFFF: imem_icode = 4'h0;
                default:      imem_icode = 4'h1;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        ovr_en = 1'b0; ovr_icode = 4'h1;
        tick();
        n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
        n_checks++; if (imem_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", imem_pc); end
        n_checks++; if ({halted, instr_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {halted, instr_err}); end
        n_checks++; if ({d_icode, d_valC, d_valP, d_pc} !== '0) begin n_fail++; $display("FAIL reset_fields got %h want 0", {d_icode, d_valC, d_valP, d_pc}); end
        rst = 1'b0;
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_icode !== 4'h3 || d_valC !== 32'h100) begin
            n_fail++; $display("FAIL irmovl_issue got v=%b ic=%h valC=%h want v=1 ic=3 valC=100", d_valid, d_icode, d_valC); end
        n_checks++; if (d_pc !== 32'h0 || d_valP !== 32'h6 || imem_pc !== 32'h6) begin
            n_fail++; $display("FAIL irmovl_pcs got pc=%h valP=%h imem=%h want 0 6 6", d_pc, d_valP, imem_pc); end
    endtask

    task automatic test_stall_and_call();
        tick();
        n_checks++; if (d_icode !== 4'h1 || d_pc !== 32'h6 || imem_pc !== 32'h7) begin
            n_fail++; $display("FAIL nop_issue got ic=%h pc=%h imem=%h want 1 6 7", d_icode, d_pc, imem_pc); end
        tick();
        n_checks++; if (d_icode !== 4'h6 || d_pc !== 32'h7 || d_valP !== 32'h9 || imem_pc !== 32'h9) begin
            n_fail++; $display("FAIL opl_issue got ic=%h pc=%h valP=%h imem=%h want 6 7 9 9", d_icode, d_pc, d_valP, imem_pc); end
        d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (d_valid !== 1'b1 || d_pc !== 32'h7 || d_valP !== 32'h9 || imem_pc !== 32'h9) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%b pc=%h valP=%h imem=%h want 1 7 9 9", i, d_valid, d_pc, d_valP, imem_pc); end
        end
        d_ready = 1'b1;
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_icode !== 4'h8 || d_pc !== 32'h9 || d_valP !== 32'hE || d_valC !== 32'h40) begin
            n_fail++; $display("FAIL call_issue got v=%b ic=%h pc=%h valP=%h valC=%h want 1 8 9 e 40", d_valid, d_icode, d_pc, d_valP, d_valC); end
`ifdef FETCH_PREDICT_TAKEN_EN
        n_checks++; if (imem_pc !== 32'h40) begin n_fail++; $display("FAIL call_predict got %h want 40", imem_pc); end
`else
        n_checks++; if (imem_pc !== 32'hE) begin n_fail++; $display("FAIL call_predict got %h want e", imem_pc); end
`endif
    endtask

    task automatic test_ret_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (d_valid !== 1'b0 || imem_pc !== 32'h40) begin
            n_fail++; $display("FAIL redirect_40 got v=%b imem=%h want 0 40", d_valid, imem_pc); end
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_icode !== 4'h9 || d_pc !== 32'h40 || d_valP !== 32'h41) begin
            n_fail++; $display("FAIL ret_issue got v=%b ic=%h pc=%h valP=%h want 1 9 40 41", d_valid, d_icode, d_pc, d_valP); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL ret_wait[%0d] got v=%b want 0", i, d_valid); end
        end
        redirect_valid = 1'b1; redirect_pc = 32'hE;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (d_valid !== 1'b0 || imem_pc !== 32'hE) begin
            n_fail++; $display("FAIL ret_redirect got v=%b imem=%h want 0 e", d_valid, imem_pc); end
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_pc !== 32'hE || imem_pc !== 32'hF) begin
            n_fail++; $display("FAIL resume got v=%b pc=%h imem=%h want 1 e f", d_valid, d_pc, imem_pc); end
    endtask

    task automatic test_redirect_over_stall();
        d_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (d_valid !== 1'b0 || imem_pc !== 32'h20) begin
            n_fail++; $display("FAIL redirect_stall got v=%b imem=%h want 0 20", d_valid, imem_pc); end
        d_ready = 1'b1;
    endtask

    task automatic test_illegal_and_halt();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (instr_err !== 1'b1 || d_valid !== 1'b0 || imem_pc !== 32'h20 || halted !== 1'b0) begin
                n_fail++; $display("FAIL illegal[%0d] got err=%b v=%b imem=%h h=%b want 1 0 20 0", i, instr_err, d_valid, imem_pc, halted); end
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFF;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (instr_err !== 1'b0 || imem_pc !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL err_exit got err=%b imem=%h want 0 ffffffff", instr_err, imem_pc); end
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_icode !== 4'h0 || d_pc !== 32'hFFFFFFFF || d_valP !== 32'h0) begin
            n_fail++; $display("FAIL halt_issue got v=%b ic=%h pc=%h valP=%h want 1 0 ffffffff 0", d_valid, d_icode, d_pc, d_valP); end
        n_checks++; if (halted !== 1'b1 || imem_pc !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL halt_state got h=%b imem=%h want 1 ffffffff", halted, imem_pc); end
        tick();
        n_checks++; if (d_valid !== 1'b0 || halted !== 1'b1 || imem_pc !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL halt_drain got v=%b h=%b imem=%h want 0 1 ffffffff", d_valid, halted, imem_pc); end
    endtask

    task automatic test_lengths();
        logic [3:0] ic [10];
        logic [2:0] ln [10];
        logic [31:0] want_pc;
        ic = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB};
        ln = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6, 3'd2, 3'd5, 3'd5, 3'd2, 3'd2};
        ovr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ovr_icode = ic[i];
            redirect_valid = 1'b1; redirect_pc = 32'h200;
            tick();
            redirect_valid = 1'b0;
            tick();
            want_pc = 32'h200 + 32'(ln[i]);
`ifdef FETCH_PREDICT_TAKEN_EN
            if (ic[i] == 4'h7 || ic[i] == 4'h8) want_pc = 32'h300;
`endif
            n_checks++; if (d_valid !== 1'b1 || d_icode !== ic[i] || d_valP !== 32'h200 + 32'(ln[i]) || imem_pc !== want_pc) begin
                n_fail++; $display("FAIL length_ic%h got v=%b ic=%h valP=%h imem=%h want 1 %h %h %h",
                                   ic[i], d_valid, d_icode, d_valP, imem_pc, ic[i], 32'h200 + 32'(ln[i]), want_pc); end
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (d_valid !== 1'b0 || imem_pc !== 32'h0 || d_pc !== 32'h0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%b imem=%h pc=%h h=%b want 0 0 0 0", d_valid, imem_pc, d_pc, halted); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stall_and_call();
        test_ret_wait();
        test_redirect_over_stall();
        test_illegal_and_halt();
        test_lengths();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
